// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module      : ps2_host_tx
// Description : PS/2 host-to-device command transmitter (open-drain _oe outputs).
//               Optional resend on NACK/timeout when PS2_TX_RESEND_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES     = 6000,
    parameter int START_SETUP_CYCLES = 50,
    parameter int TIMEOUT_CYCLES     = 750000,
    parameter int SYNC_STAGES        = 2,
    parameter int MAX_RETRIES        = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_error
);

    localparam int c_CNT_MAX = (INHIBIT_CYCLES > START_SETUP_CYCLES) ? INHIBIT_CYCLES
                                                                     : START_SETUP_CYCLES;
    localparam int c_CNT_W = $clog2(c_CNT_MAX + 1);
    localparam int c_TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_INH_LAST   = c_CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_START_LAST = c_CNT_W'(START_SETUP_CYCLES - 1);
    localparam logic [c_TO_W-1:0]  c_TO_LAST    = c_TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INHIBIT   = 3'd1,
        ST_START     = 3'd2,
        ST_SEND      = 3'd3,
        ST_ACK       = 3'd4,
        ST_WAIT_IDLE = 3'd5,
        ST_FAIL      = 3'd6
    } state_t;

    state_t               r_state,   w_state_nx;
    logic [c_CNT_W-1:0]   r_cnt,     w_cnt_nx;
    logic [c_TO_W-1:0]    r_tcnt,    w_tcnt_nx;
    logic [3:0]           r_n,       w_n_nx;
    logic [7:0]           r_data,    w_data_nx;
    logic                 r_par,     w_par_nx;
    logic                 r_clk_oe,  w_clk_oe_nx;
    logic                 r_dat_oe,  w_dat_oe_nx;
    logic                 r_done,    w_done_nx;
    logic                 r_err,     w_err_nx;
    logic [SYNC_STAGES-1:0] r_clk_sync;
    logic [SYNC_STAGES-1:0] r_dat_sync;
    logic                 r_fe;
    logic                 w_clk_s;
    logic                 w_dat_s;
    logic                 w_final;

`ifdef PS2_TX_RESEND_EN
    localparam int c_RTY_W = $clog2(MAX_RETRIES + 2);
    logic [c_RTY_W-1:0]   r_retry,   w_retry_nx;
    assign w_final = (r_retry == c_RTY_W'(MAX_RETRIES));
`else
    assign w_final = 1'b1;
`endif

    // The falling edge is flagged in the same cycle the synchronised clock reads 0.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_clk_sync <= '1;
            r_dat_sync <= '1;
            r_fe       <= 1'b0;
        end else begin
            r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], ps2_clk_in};
            r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], ps2_dat_in};
            r_fe       <= r_clk_sync[SYNC_STAGES-1] & ~r_clk_sync[SYNC_STAGES-2];
        end
    end

    assign w_clk_s  = r_clk_sync[SYNC_STAGES-1];
    assign w_dat_s  = r_dat_sync[SYNC_STAGES-1];
    assign tx_ready = ~reset & (r_state == ST_IDLE) & w_clk_s & w_dat_s;

    always_comb begin
        w_state_nx  = r_state;
        w_cnt_nx    = r_cnt;
        w_tcnt_nx   = r_tcnt;
        w_n_nx      = r_n;
        w_data_nx   = r_data;
        w_par_nx    = r_par;
        w_clk_oe_nx = r_clk_oe;
        w_dat_oe_nx = r_dat_oe;
        w_done_nx   = 1'b0;
        w_err_nx    = 1'b0;
`ifdef PS2_TX_RESEND_EN
        w_retry_nx  = r_retry;
`endif
        case (r_state)
            ST_IDLE: begin
                if (tx_valid && tx_ready) begin
                    w_state_nx  = ST_INHIBIT;
                    w_data_nx   = tx_data;
                    w_par_nx    = ~^tx_data;
                    w_n_nx      = 4'd0;
                    w_cnt_nx    = '0;
                    w_clk_oe_nx = 1'b1;
                    w_dat_oe_nx = 1'b0;
`ifdef PS2_TX_RESEND_EN
                    w_retry_nx  = '0;
`endif
                end
            end
            ST_INHIBIT: begin
                if (r_cnt == c_INH_LAST) begin
                    w_state_nx  = ST_START;
                    w_cnt_nx    = '0;
                    w_dat_oe_nx = 1'b1;
                end else begin
                    w_cnt_nx = r_cnt + c_CNT_W'(1);
                end
            end
            ST_START: begin
                if (r_cnt == c_START_LAST) begin
                    w_state_nx  = ST_SEND;
                    w_clk_oe_nx = 1'b0;
                    w_tcnt_nx   = '0;
                end else begin
                    w_cnt_nx = r_cnt + c_CNT_W'(1);
                end
            end
            ST_SEND, ST_ACK, ST_WAIT_IDLE: begin
                // Timeout expiry takes precedence over a coincident clock edge.
                if (r_tcnt == c_TO_LAST) begin
                    w_state_nx  = ST_FAIL;
                    w_clk_oe_nx = 1'b0;
                    w_dat_oe_nx = 1'b0;
                    w_err_nx    = w_final;
                end else begin
                    w_tcnt_nx = r_tcnt + c_TO_W'(1);
                    if (r_state == ST_SEND) begin
                        if (r_fe) begin
                            w_n_nx = r_n + 4'd1;
                            if (r_n < 4'd8) begin
                                w_dat_oe_nx = ~r_data[r_n[2:0]];
                            end else if (r_n == 4'd8) begin
                                w_dat_oe_nx = ~r_par;
                            end else begin
                                w_dat_oe_nx = 1'b0;
                                w_state_nx  = ST_ACK;
                            end
                        end
                    end else if (r_state == ST_ACK) begin
                        if (r_fe) begin
                            if (!w_dat_s) begin
                                w_state_nx = ST_WAIT_IDLE;
                            end else begin
                                w_state_nx  = ST_FAIL;
                                w_clk_oe_nx = 1'b0;
                                w_dat_oe_nx = 1'b0;
                                w_err_nx    = w_final;
                            end
                        end
                    end else begin
                        if (w_clk_s && w_dat_s) begin
                            w_state_nx = ST_IDLE;
                            w_done_nx  = 1'b1;
                        end
                    end
                end
            end
            ST_FAIL: begin
                w_clk_oe_nx = 1'b0;
                w_dat_oe_nx = 1'b0;
                w_state_nx  = ST_IDLE;
`ifdef PS2_TX_RESEND_EN
                if (!w_final) begin
                    w_retry_nx  = r_retry + c_RTY_W'(1);
                    w_state_nx  = ST_INHIBIT;
                    w_cnt_nx    = '0;
                    w_n_nx      = 4'd0;
                    w_clk_oe_nx = 1'b1;
                end
`endif
            end
            default: begin
                w_state_nx  = ST_IDLE;
                w_clk_oe_nx = 1'b0;
                w_dat_oe_nx = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_tcnt   <= '0;
            r_n      <= 4'd0;
            r_data   <= 8'd0;
            r_par    <= 1'b0;
            r_clk_oe <= 1'b0;
            r_dat_oe <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
`ifdef PS2_TX_RESEND_EN
            r_retry  <= '0;
`endif
        end else begin
            r_state  <= w_state_nx;
            r_cnt    <= w_cnt_nx;
            r_tcnt   <= w_tcnt_nx;
            r_n      <= w_n_nx;
            r_data   <= w_data_nx;
            r_par    <= w_par_nx;
            r_clk_oe <= w_clk_oe_nx;
            r_dat_oe <= w_dat_oe_nx;
            r_done   <= w_done_nx;
            r_err    <= w_err_nx;
`ifdef PS2_TX_RESEND_EN
            r_retry  <= w_retry_nx;
`endif
        end
    end

    assign ps2_clk_oe = r_clk_oe;
    assign ps2_dat_oe = r_dat_oe;
    assign busy       = (r_state != ST_IDLE);
    assign tx_done    = r_done;
    assign tx_error   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_host_tx
// Description : Self-checking bench for ps2_host_tx with a PS/2 device model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_host_tx;

    localparam int INH = 40;
    localparam int STS = 8;
    localparam int TMO = 2000;
    localparam int SYN = 2;
    localparam int RET = 2;
`ifdef PS2_TX_RESEND_EN
    localparam int ATTEMPTS = RET + 1;
`else
    localparam int ATTEMPTS = 1;
`endif
    localparam int M_ACK  = 0;
    localparam int M_NACK = 1;
    localparam int M_RST  = 2;

    logic       clock    = 1'b0;
    logic       reset    = 1'b1;
    logic [7:0] tx_data  = 8'd0;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       ps2_clk_oe;
    logic       ps2_dat_oe;
    logic       busy;
    logic       tx_done;
    logic       tx_error;
    logic       dev_clk  = 1'b1;
    logic       dev_dat  = 1'b1;
    logic       w_clk_line;
    logic       w_dat_line;

    // Open-drain bus: either side may pull a line low.
    assign w_clk_line = ~ps2_clk_oe & dev_clk;
    assign w_dat_line = ~ps2_dat_oe & dev_dat;

    ps2_host_tx #(
        .INHIBIT_CYCLES    (INH),
        .START_SETUP_CYCLES(STS),
        .TIMEOUT_CYCLES    (TMO),
        .SYNC_STAGES       (SYN),
        .MAX_RETRIES       (RET)
    ) u_dut (
        .clock     (clock),
        .reset     (reset),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .ps2_clk_in(w_clk_line),
        .ps2_dat_in(w_dat_line),
        .ps2_clk_oe(ps2_clk_oe),
        .ps2_dat_oe(ps2_dat_oe),
        .busy      (busy),
        .tx_done   (tx_done),
        .tx_error  (tx_error)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_inh    = 0;
    int n_done   = 0;
    int n_err    = 0;
    int n_both   = 0;
    int last_exit = 0;
    int done_cyc = 0;
    int inh_cyc  = 0;
    logic m_prev_clk_oe = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    // Event monitor: inhibit starts, start-setup exits, completion pulses.
    always @(negedge clock) begin
        m_prev_clk_oe <= ps2_clk_oe;
        if (ps2_clk_oe && !m_prev_clk_oe) begin
            n_inh   <= n_inh + 1;
            inh_cyc <= cyc;
        end
        if (!ps2_clk_oe && m_prev_clk_oe && ps2_dat_oe) last_exit <= cyc;
        if (tx_done) begin
            n_done   <= n_done + 1;
            done_cyc <= cyc;
        end
        if (tx_error) n_err <= n_err + 1;
        if (tx_done && tx_error) n_both <= n_both + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference frame: 8 data bits LSB first, odd parity, stop bit 1.
    function automatic logic [9:0] frame_of(input logic [7:0] b);
        logic par;
        par = ($countones(b) % 2 == 0) ? 1'b1 : 1'b0;
        return {1'b1, par, b};
    endfunction

    task automatic request(input logic [7:0] b, input bit keep);
        int k;
        k = 0;
        while (!tx_ready && k < 500) begin
            @(negedge clock);
            k++;
        end
        check_eq("request_ready", {31'd0, tx_ready}, 32'd1);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clock);
        if (!keep) tx_valid = 1'b0;
    endtask

    task automatic run_xfer(input logic [7:0] b, input int mode, input bit keep, input int h);
        logic [9:0] got;
        int k, cnt, gd, ge, snap_d, snap_e;
        got = '0;
        k = 0;
        while (!ps2_clk_oe && k < 200) begin
            @(negedge clock);
            k++;
        end
        if (!keep) tx_valid = 1'b0;
        cnt = 0;
        while (ps2_clk_oe && !ps2_dat_oe && cnt < 10 * INH) begin
            cnt++;
            @(negedge clock);
        end
        check_eq("inhibit_len", cnt, INH);
        cnt = 0;
        while (ps2_clk_oe && ps2_dat_oe && cnt < 10 * STS) begin
            cnt++;
            @(negedge clock);
        end
        check_eq("start_setup_len", cnt, STS);
        check_eq("start_bit_low", {30'd0, w_clk_line, w_dat_line}, 32'd2);
        repeat ($urandom_range(2, 20)) @(negedge clock);
        gd = 0;
        ge = 0;
        snap_d = n_done;
        snap_e = n_err;
        for (int i = 1; i <= 11; i++) begin
            if (i == 11 && mode == M_ACK) dev_dat = 1'b0;
            dev_clk = 1'b0;
            if (mode == M_RST && i == 5) begin
                repeat (SYN + 2) @(negedge clock);
                reset = 1'b1;
                @(negedge clock);
                check_eq("rst_release_oe", {30'd0, ps2_clk_oe, ps2_dat_oe}, 32'd0);
                check_eq("rst_busy", {31'd0, busy}, 32'd0);
                reset   = 1'b0;
                dev_clk = 1'b1;
                repeat (30) @(negedge clock);
                #1;
                check_eq("rst_no_done", n_done - snap_d, 0);
                check_eq("rst_no_error", n_err - snap_e, 0);
                return;
            end
            for (int j = 0; j < h; j++) begin
                @(negedge clock);
                gd += int'(tx_done);
                ge += int'(tx_error);
            end
            if (i <= 10) got[i-1] = w_dat_line;
            dev_clk = 1'b1;
            dev_dat = 1'b1;
            if (i < 11) repeat (h) @(negedge clock);
        end
        check_eq("frame_bits", {22'd0, got}, {22'd0, frame_of(b)});
        k = 0;
        while (gd + ge == 0 && k < 50) begin
            @(negedge clock);
            gd += int'(tx_done);
            ge += int'(tx_error);
            k++;
        end
        if (mode == M_ACK)
            check_eq("done_lines_high", {30'd0, w_clk_line, w_dat_line}, 32'd3);
        check_eq("done_count", gd, (mode == M_ACK) ? 1 : 0);
        check_eq("error_count", ge, (mode == M_NACK) ? 1 : 0);
        @(negedge clock);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        int k, bad, snap_i, snap_e, snap_d;

        repeat (3) @(negedge clock);
        check_eq("reset_outputs",
                 {26'd0, tx_ready, ps2_clk_oe, ps2_dat_oe, busy, tx_done, tx_error}, 32'd0);
        reset = 1'b0;
        repeat (SYN + 1) @(negedge clock);
        check_eq("ready_after_reset", {31'd0, tx_ready}, 32'd1);

        request(8'hED, 1'b0);
        run_xfer(8'hED, M_ACK, 1'b0, 25);
        check_eq("ed_lines_released", {30'd0, ps2_clk_oe, ps2_dat_oe}, 32'd0);

        repeat (4) begin
            b = 8'($urandom);
            request(b, 1'b0);
            run_xfer(b, M_ACK, 1'b0, $urandom_range(8, 30));
        end

        snap_i = n_inh;
        request(8'h02, 1'b1);
        tx_data = 8'hF4;
        run_xfer(8'h02, M_ACK, 1'b1, 15);
        #1;
        check_eq("b2b_inhibits", n_inh - snap_i, 2);
        check_eq("b2b_start_after_done", inh_cyc - done_cyc, 1);
        run_xfer(8'hF4, M_ACK, 1'b0, 15);

`ifndef PS2_TX_RESEND_EN
        b = 8'($urandom);
        request(b, 1'b0);
        run_xfer(b, M_NACK, 1'b0, 20);
        check_eq("nack_lines_released", {30'd0, ps2_clk_oe, ps2_dat_oe}, 32'd0);
        k = 0;
        while (!tx_ready && k < 10) begin
            @(negedge clock);
            k++;
        end
        check_eq("nack_ready_again", {31'd0, tx_ready}, 32'd1);
`endif

        snap_i = n_inh;
        snap_e = n_err;
        snap_d = n_done;
        request(8'($urandom), 1'b0);
        k = 0;
        while (!tx_error && k < ATTEMPTS * (INH + STS + TMO + 20)) begin
            @(negedge clock);
            k++;
        end
        check_eq("timeout_error_seen", {31'd0, tx_error}, 32'd1);
        check_eq("timeout_latency", cyc - last_exit, TMO);
        @(negedge clock);
        #1;
        check_eq("timeout_error_once", n_err - snap_e, 1);
        check_eq("timeout_no_done", n_done - snap_d, 0);
        check_eq("timeout_attempts", n_inh - snap_i, ATTEMPTS);
        check_eq("timeout_lines_released", {30'd0, ps2_clk_oe, ps2_dat_oe}, 32'd0);

        b = 8'($urandom);
        request(b, 1'b0);
        run_xfer(b, M_RST, 1'b0, 15);
        b = 8'($urandom);
        request(b, 1'b0);
        run_xfer(b, M_ACK, 1'b0, 15);

        @(negedge clock);
        dev_clk = 1'b0;
        repeat (SYN + 2) @(negedge clock);
        snap_i   = n_inh;
        b        = 8'($urandom);
        tx_data  = b;
        tx_valid = 1'b1;
        bad = 0;
        repeat (30) begin
            @(negedge clock);
            if (tx_ready || ps2_clk_oe) bad++;
        end
        #1;
        check_eq("bus_busy_held_off", bad, 0);
        check_eq("bus_busy_no_inhibit", n_inh - snap_i, 0);
        dev_clk = 1'b1;
        k = 0;
        while (!ps2_clk_oe && k < 20) begin
            @(negedge clock);
            k++;
        end
        check_eq("bus_idle_to_inhibit", k, SYN + 1);
        run_xfer(b, M_ACK, 1'b0, 20);

        repeat (5) @(negedge clock);
        check_eq("never_done_with_error", n_both, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
